// File: rtl/mul8x8_seq_ctrl_pkg.sv
// Shared definitions for the sequential 8x8 multiplier: controller state
// encoding and partial-product step count.
package mul8x8_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int unsigned N_STEPS   = 4;
    localparam logic [1:0]  LAST_STEP = 2'(N_STEPS - 1);

endpackage

// File: rtl/mul8x8_seq_ctrl_mul.sv
// Combinational W x W unsigned multiplier slice; the only arithmetic
// multiplier in the sequencer.
module Mul #(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0]   data_a,
    input  logic [W-1:0]   data_b,
    output logic [2*W-1:0] product
);

    // Full-width unsigned product of the two slice operands.
    always_comb begin
        product = {{W{1'b0}}, data_a} * {{W{1'b0}}, data_b};
    end

endmodule

// File: rtl/mul8x8_seq_ctrl.sv
// Sequencer building a 2*HALF_W x 2*HALF_W unsigned multiply from one
// HALF_W x HALF_W slice: four partial products accumulated over four cycles,
// operands and result exchanged over valid/ready handshakes.
module mul8x8_seq_ctrl
    import mul8x8_seq_ctrl_pkg::*;
#(
    parameter int unsigned HALF_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2*HALF_W-1:0]   data_a,
    input  logic [2*HALF_W-1:0]   data_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*HALF_W-1:0]   product,
    output logic                  busy
);

    state_e                state_q, state_d;
    logic [1:0]            step_q;
    logic [2*HALF_W-1:0]   a_q, b_q;
    logic [4*HALF_W-1:0]   acc_q;
    logic [4*HALF_W-1:0]   product_q;

    logic [HALF_W-1:0]     slice_a, slice_b;
    logic [2*HALF_W-1:0]   pp;
    logic [4*HALF_W-1:0]   pp_ext, pp_shift, acc_sum;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; clear overrides every transition.
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (in_valid)             state_d = ST_MUL;
                ST_MUL:  if (step_q == LAST_STEP)  state_d = ST_DONE;
                ST_DONE: if (out_ready)            state_d = ST_IDLE;
                default:                           state_d = ST_IDLE;
            endcase
        end
    end

    // Handshake and status outputs decoded from the state.
    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_DONE);
        busy      = (state_q != ST_IDLE);
    end

    // Operand nibble select: step[1] picks the high half of a, step[0] of b.
    always_comb begin
        slice_a = step_q[1] ? a_q[2*HALF_W-1:HALF_W] : a_q[HALF_W-1:0];
        slice_b = step_q[0] ? b_q[2*HALF_W-1:HALF_W] : b_q[HALF_W-1:0];
    end

    Mul #(.W(HALF_W)) u_slice (
        .data_a  (slice_a),
        .data_b  (slice_b),
        .product (pp)
    );

    // Align the partial product to its weight and add it to the accumulator.
    always_comb begin
        pp_ext                = '0;
        pp_ext[2*HALF_W-1:0]  = pp;
        case (step_q)
            2'd0:    pp_shift = pp_ext;
            2'd3:    pp_shift = pp_ext << (2*HALF_W);
            default: pp_shift = pp_ext << HALF_W;
        endcase
        acc_sum = acc_q + pp_shift;
    end

    // Operand capture, accumulation, step counting and result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            step_q    <= '0;
            product_q <= '0;
        end else if (clear) begin
            acc_q     <= '0;
            step_q    <= '0;
            product_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_q    <= data_a;
                        b_q    <= data_b;
                        acc_q  <= '0;
                        step_q <= '0;
                    end
                end
                ST_MUL: begin
                    acc_q  <= acc_sum;
                    step_q <= step_q + 2'd1;
                    if (step_q == LAST_STEP) begin
                        product_q <= acc_sum;
                    end
                end
                default: ;
            endcase
        end
    end

    assign product = product_q;

endmodule

// File: tb/tb_mul8x8_seq_ctrl.sv
// Scoreboard bench for mul8x8_seq_ctrl: stimulus pushes expected products,
// a negedge monitor pops and compares on every output handshake.
module tb_mul8x8_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  data_a = '0;
    logic [7:0]  data_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] product;
    logic        busy;

    logic [15:0] exp_q[$];
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned n_pushed = 0;
    int unsigned n_popped = 0;

    always #5 clk = ~clk;

    mul8x8_seq_ctrl #(.HALF_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_a    (data_a),
        .data_b    (data_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Monitor: every output handshake must match the oldest expected product.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL sb_unexpected: product 0x%0h with no op outstanding", product);
            end else begin
                n_popped++;
                check("sb_product", {16'd0, product}, {16'd0, exp_q.pop_front()});
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accept edge.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input bit push);
        int unsigned t;
        t = 0;
        while (!in_ready && t < 50) begin
            @(posedge clk); #1; t++;
        end
        if (!in_ready) check("send_timeout", 32'(in_ready), 32'd1);
        data_a   = a;
        data_b   = b;
        in_valid = 1'b1;
        if (push) begin
            exp_q.push_back(16'(a) * 16'(b));
            n_pushed++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int unsigned n);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1; n++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned lat;
        int unsigned t;
        logic [7:0]  ra, rb;

        // Reset state
        #12;
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_product",   32'(product),   32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: basic op, latency 4, valid held one cycle with out_ready=1
        out_ready = 1'b1;
        send(8'h12, 8'h34, 1'b1);
        check("t1_busy", 32'(busy), 32'd1);
        wait_valid(lat);
        check("t1_latency", lat, 32'd4);
        check("t1_product", 32'(product), 32'h03A8);
        @(posedge clk); #1;
        check("t1_valid_drop", 32'(out_valid), 32'd0);
        check("t1_in_ready",   32'(in_ready),  32'd1);

        // 2: maximum operands and zero operand
        send(8'hFF, 8'hFF, 1'b1);
        wait_valid(lat);
        check("t2_latency_max", lat, 32'd4);
        check("t2_product_max", 32'(product), 32'hFE01);
        @(posedge clk); #1;
        send(8'h00, 8'hA7, 1'b1);
        wait_valid(lat);
        check("t2_latency_zero", lat, 32'd4);
        check("t2_product_zero", 32'(product), 32'h0000);
        @(posedge clk); #1;

        // 3: consumer stall, result held stable
        out_ready = 1'b0;
        send(8'h9C, 8'h0F, 1'b1);
        wait_valid(lat);
        check("t3_latency", lat, 32'd4);
        for (int i = 0; i < 3; i++) begin
            check("t3_hold_valid",   32'(out_valid), 32'd1);
            check("t3_hold_product", 32'(product),   32'h0924);
            check("t3_hold_in_rdy",  32'(in_ready),  32'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("t3_idle_after_hs", 32'(in_ready), 32'd1);
        check("t3_product_kept",  32'(product),  32'h0924);

        // 4: in_valid during MUL is ignored
        send(8'h3B, 8'hC5, 1'b1);
        data_a   = 8'h55;
        data_b   = 8'h55;
        in_valid = 1'b1;
        check("t4_in_ready_low", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_valid(lat);
        check("t4_latency_rest", lat, 32'd3);
        check("t4_product", 32'(product), 32'h2D67);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("t4_no_extra_op", 32'(busy), 32'd0);

        // 5a: async reset at step 2
        send(8'h77, 8'h22, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("t5r_in_ready",  32'(in_ready),  32'd1);
        check("t5r_out_valid", 32'(out_valid), 32'd0);
        check("t5r_product",   32'(product),   32'd0);
        check("t5r_busy",      32'(busy),      32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        send(8'h0A, 8'h0B, 1'b1);
        wait_valid(lat);
        check("t5r_next_latency", lat, 32'd4);
        check("t5r_next_product", 32'(product), 32'h006E);
        @(posedge clk); #1;

        // 5b: synchronous clear at step 1
        send(8'h77, 8'h22, 1'b0);
        @(posedge clk); #1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        check("t5c_in_ready",  32'(in_ready),  32'd1);
        check("t5c_out_valid", 32'(out_valid), 32'd0);
        check("t5c_product",   32'(product),   32'd0);
        @(posedge clk); #1;
        check("t5c_stays_idle", 32'(busy), 32'd0);
        send(8'hC3, 8'h3C, 1'b1);
        wait_valid(lat);
        check("t5c_next_latency", lat, 32'd4);
        check("t5c_next_product", 32'(product), 32'h2DB4);
        @(posedge clk); #1;

        // 6: random operands with random consumer stalls
        for (int k = 0; k < 1000; k++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            send(ra, rb, 1'b1);
            t = 0;
            do begin
                @(posedge clk); #1;
                out_ready = 1'($urandom_range(0, 1));
                t++;
            end while (!in_ready && t < 100);
            if (!in_ready) check("t6_timeout", 32'(in_ready), 32'd1);
        end

        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("hs_count", n_popped, n_pushed);
        check("sb_drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
